video_stream_expander: RTL and testbench
========================================

Name: video_stream_expander

Overview:
- Parametrised Avalon-ST colour expander between the packed-pixel source (camera/frame buffer) and the VGA output stream.
- Takes packed RGB pixels of IN_BITS per channel and emits OUT_BITS per channel plus zero padding.
- Runtime-selectable expansion mode. Real sink-side backpressure through a 2-entry skid FIFO.
- Generates frame sop/eop from a pixel counter, resynchronises on sop_in, and flags framing errors.

Parameters:
- NumPixels, 320*240, pixels per frame.
- IN_BITS, 4, input bits per colour channel (1..OUT_BITS).
- OUT_BITS, 8, output colour bits per channel.
- PAD_BITS, 2, zero LSB padding per output channel.
- CNT_W, 19, pixel counter width (2**CNT_W >= NumPixels).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- data_in  in  3*IN_BITS  packed {R,G,B}, R in MSBs
- sop_in  in  1  input start of frame
- eop_in  in  1  input end of frame
- valid_in  in  1  input beat valid
- ready_in  out  1  block can accept a beat
- mode  in  2  0=replicate, 1=zero-fill, 2=grey, 3=treated as 0
- data  out  3*(OUT_BITS+PAD_BITS)  {R,pad,G,pad,B,pad}
- startofpacket  out  1  output sop
- endofpacket  out  1  output eop
- valid  out  1  output beat valid
- ready  in  1  downstream ready
- sync_err  out  1  sticky framing error
- frame_count  out  16  completed output frames, wraps

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty, pixel counter 0, frame_count 0, sync_err 0, active mode 0. Outputs valid=0, ready_in=0, data/sop/eop=0.
- Reset is released synchronously. ready_in=1 from the first clock edge after release.
- Handshakes:
  - Input accepted when valid_in & ready_in.
  - Output transfer when valid & ready.
  - ready_in = (FIFO count < 2), registered (no combinational path from ready).
  - valid = (FIFO count > 0).
  - data/sop/eop hold stable while valid & !ready.
- Latency: a beat accepted on edge N is presented on the output after edge N. Minimum latency 1 cycle. Full throughput of 1 beat/cycle when ready is held high.
- Simultaneous push and pop: count is unchanged. Push into a full FIFO is impossible since ready_in=0.
- Pixel counter (advances on input acceptance):
  - Each accepted beat is tagged sop = (idx==0) and eop = (idx==NumPixels-1).
  - Next idx = 0 if idx==NumPixels-1, else idx+1.
- sop_in resync:
  - sop_in=1 with idx!=0: the beat is tagged idx 0 (sop=1), the counter continues from 1, and sync_err is set.
  - sop_in=0 at idx 0 is not an error.
- eop_in mismatch: eop_in differing from (idx==NumPixels-1) on an accepted beat sets sync_err. Generated tags are unaffected.
- sync_err is sticky until reset.
- frame_count increments on each output transfer with endofpacket=1.
- Mode latch: mode is sampled into the active mode only on an accepted beat tagged sop. That beat and the rest of the frame use the new mode. Mid-frame mode changes are ignored.
- Expansion per channel c (IN_BITS wide), OUT_BITS result, then PAD_BITS zeros appended:
  - Mode 0: c replicated ceil(OUT_BITS/IN_BITS) times, truncated to the OUT_BITS MSBs (4->8: 0xA -> 0xAA; 1->8: 1 -> 0xFF).
  - Mode 1: c in MSBs, LSBs zero (0xA -> 0xA0).
  - Mode 2: y = (R + 2G + B) >> 2 in IN_BITS+2-bit arithmetic, truncated to IN_BITS. y is expanded as in mode 0 and driven on all three channels.
- Expansion is computed at FIFO write. The FIFO stores the expanded word plus sop/eop.
- Reset mid-frame: FIFO contents are dropped and the counter returns to 0. The next accepted beat is sop.

Test Plan:
- Reset, ready=1, stream 4 beats data_in=0xA5F in mode 0 → output data = {AA,00,55,00,FF,00} per channel field, valid 1 cycle after each accept, beat 0 sop=1.
- NumPixels=12: stream 12 beats with correct sop_in/eop_in, then a second frame → eop on beats 11 and 23, frame_count=2, sync_err=0.
- Hold ready=0 for 5 cycles while valid_in=1 → exactly 2 beats absorbed, ready_in=0, output word stable. Release ready → no beat lost or duplicated; compare ordered sequence against model.
- Mode 1 then mode 2 with data_in=0xF00 → 0xF0/0x00/0x00 in mode 1; grey (15>>2=3) gives 0x33 on all channels in mode 2. Mode change mid-frame takes effect only at the next sop.
- sop_in=1 at idx 5 → that output beat has startofpacket=1, sync_err=1 and stays 1. Next eop occurs NumPixels-1 beats later.
- Assert reset_n low mid-frame with FIFO full → valid=0 and ready_in=0 immediately (asynchronous). After release, the first accepted beat carries sop=1 and frame_count=0.

Source files
------------

// File: rtl/video_stream_expander.sv
// Avalon-ST colour expander: packed IN_BITS/channel RGB in, padded OUT_BITS/channel RGB out,
// with frame tagging from a pixel counter and a 2-entry skid FIFO for sink backpressure.
module video_stream_expander #(
  parameter int NumPixels = 320*240,
  parameter int IN_BITS   = 4,
  parameter int OUT_BITS  = 8,
  parameter int PAD_BITS  = 2,
  parameter int CNT_W     = 19
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [3*IN_BITS-1:0]             data_in,
  input  logic                             sop_in,
  input  logic                             eop_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [1:0]                       mode,
  output logic [3*(OUT_BITS+PAD_BITS)-1:0] data,
  output logic                             startofpacket,
  output logic                             endofpacket,
  output logic                             valid,
  input  logic                             ready,
  output logic                             sync_err,
  output logic [15:0]                      frame_count
);

  localparam int WordW = 3*(OUT_BITS+PAD_BITS);
  localparam int EntW  = WordW + 2;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NumPixels - 1);

  function automatic logic [OUT_BITS-1:0] replicate(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      r[OUT_BITS-1-i] = c[IN_BITS-1-(i % IN_BITS)];
    end
    return r;
  endfunction

  function automatic logic [OUT_BITS-1:0] zero_fill(input logic [IN_BITS-1:0] c);
    logic [OUT_BITS-1:0] r;
    r = '0;
    r[OUT_BITS-1 -: IN_BITS] = c;
    return r;
  endfunction

  // Luma approximation (R + 2G + B) / 4 kept in IN_BITS+2 bits so the sum cannot overflow.
  function automatic logic [IN_BITS-1:0] grey(input logic [IN_BITS-1:0] r,
                                              input logic [IN_BITS-1:0] g,
                                              input logic [IN_BITS-1:0] b);
    logic [IN_BITS+1:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[IN_BITS+1:2];
  endfunction

  function automatic logic [WordW-1:0] expand_word(input logic [3*IN_BITS-1:0] d,
                                                   input logic [1:0] md);
    logic [IN_BITS-1:0]  cr, cg, cb, y;
    logic [OUT_BITS-1:0] er, eg, eb;
    cr = d[3*IN_BITS-1 -: IN_BITS];
    cg = d[2*IN_BITS-1 -: IN_BITS];
    cb = d[IN_BITS-1:0];
    y  = grey(cr, cg, cb);
    case (md)
      2'd1: begin
        er = zero_fill(cr);
        eg = zero_fill(cg);
        eb = zero_fill(cb);
      end
      2'd2: begin
        er = replicate(y);
        eg = replicate(y);
        eb = replicate(y);
      end
      default: begin
        er = replicate(cr);
        eg = replicate(cg);
        eb = replicate(cb);
      end
    endcase
    return {er, {PAD_BITS{1'b0}}, eg, {PAD_BITS{1'b0}}, eb, {PAD_BITS{1'b0}}};
  endfunction

  logic [EntW-1:0]  head_r, skid_r;
  logic [1:0]       count_r, count_nxt_s;
  logic             valid_r, ready_in_r, sync_err_r;
  logic [15:0]      frame_count_r;
  logic [CNT_W-1:0] idx_r, eff_idx_s;
  logic [1:0]       mode_r, new_mode_s, use_mode_s;
  logic             push_s, pop_s, tag_sop_s, tag_eop_s, err_s;
  logic [EntW-1:0]  entry_s;

  assign ready_in      = ready_in_r;
  assign valid         = valid_r;
  assign data          = head_r[EntW-1:2];
  assign startofpacket = head_r[1];
  assign endofpacket   = head_r[0];
  assign sync_err      = sync_err_r;
  assign frame_count   = frame_count_r;

  // Handshakes, frame tagging of the incoming beat and next FIFO occupancy.
  always_comb begin
    push_s      = valid_in & ready_in_r;
    pop_s       = valid_r & ready;
    eff_idx_s   = sop_in ? '0 : idx_r;
    tag_sop_s   = (eff_idx_s == '0);
    tag_eop_s   = (eff_idx_s == LastIdx);
    new_mode_s  = (mode == 2'd3) ? 2'd0 : mode;
    use_mode_s  = tag_sop_s ? new_mode_s : mode_r;
    entry_s     = {expand_word(data_in, use_mode_s), tag_sop_s, tag_eop_s};
    err_s       = (sop_in & (idx_r != '0)) | (eop_in != tag_eop_s);
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Skid FIFO: head_r is always the presented beat, skid_r holds the second entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_r        <= '0;
      skid_r        <= '0;
      count_r       <= 2'd0;
      valid_r       <= 1'b0;
      ready_in_r    <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != 2'd0);
      ready_in_r <= (count_nxt_s < 2'd2);
      if (push_s && ((!pop_s && count_r == 2'd0) || (pop_s && count_r == 2'd1))) begin
        head_r <= entry_s;
      end else if (pop_s && count_r == 2'd2) begin
        head_r <= skid_r;
      end
      if (push_s && ((!pop_s && count_r == 2'd1) || (pop_s && count_r == 2'd2))) begin
        skid_r <= entry_s;
      end
      if (pop_s && head_r[0]) begin
        frame_count_r <= frame_count_r + 16'd1;
      end
    end
  end

  // Pixel counter, per-frame mode latch and sticky framing error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_r      <= '0;
      mode_r     <= 2'd0;
      sync_err_r <= 1'b0;
    end else if (push_s) begin
      idx_r <= tag_eop_s ? '0 : eff_idx_s + CNT_W'(1);
      if (tag_sop_s) begin
        mode_r <= new_mode_s;
      end
      if (err_s) begin
        sync_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_expander.sv
// Scoreboard bench for video_stream_expander with a 12-pixel frame: a negedge monitor models
// tagging/expansion on accept and compares each output transfer in order.
module tb_video_stream_expander;

  localparam int NP = 12;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] data_in;
  logic        sop_in, eop_in, valid_in, ready_in;
  logic [1:0]  mode;
  logic [29:0] data;
  logic        startofpacket, endofpacket, valid, ready, sync_err;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  int          m_idx = 0;
  logic [1:0]  m_mode = 2'd0;
  logic        m_err = 1'b0;
  int          m_frames = 0;
  int          tx_idx = 0;

  video_stream_expander #(.NumPixels(NP), .IN_BITS(4), .OUT_BITS(8), .PAD_BITS(2), .CNT_W(19)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_in(ready_in), .mode(mode), .data(data),
    .startofpacket(startofpacket), .endofpacket(endofpacket), .valid(valid), .ready(ready),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] model_expand(input logic [11:0] d, input logic [1:0] md);
    logic [3:0] c[3];
    logic [7:0] o[3];
    logic [3:0] yv;
    int y;
    c[0] = d[11:8];
    c[1] = d[7:4];
    c[2] = d[3:0];
    y  = (int'(c[0]) + 2 * int'(c[1]) + int'(c[2])) / 4;
    yv = 4'(y);
    for (int i = 0; i < 3; i++) begin
      case (md)
        2'd1:    o[i] = {c[i], 4'h0};
        2'd2:    o[i] = {yv, yv};
        default: o[i] = {c[i], c[i]};
      endcase
    end
    return {o[0], 2'b00, o[1], 2'b00, o[2], 2'b00};
  endfunction

  // Monitor: retire output transfers against the scoreboard, then model newly accepted beats.
  always @(negedge clk) begin
    logic [31:0] e;
    logic        s, eo;
    if (!reset_n) begin
      sb.delete();
      m_idx = 0; m_mode = 2'd0; m_err = 1'b0; m_frames = 0;
    end else begin
      checks++;
      if (valid !== (sb.size() != 0)) begin
        errors++;
        $display("FAIL valid_vs_model: got %b expected %b", valid, sb.size() != 0);
      end
      if (valid && ready && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({data, startofpacket, endofpacket} !== e) begin
          errors++;
          $display("FAIL out_beat: got %h/%b/%b expected %h/%b/%b",
                   data, startofpacket, endofpacket, e[31:2], e[1], e[0]);
        end
        if (e[0]) m_frames++;
      end
      if (valid_in && ready_in) begin
        if (sop_in) begin
          if (m_idx != 0) m_err = 1'b1;
          m_idx = 0;
        end
        s  = (m_idx == 0);
        eo = (m_idx == NP - 1);
        if (s) m_mode = (mode == 2'd3) ? 2'd0 : mode;
        if (eop_in != eo) m_err = 1'b1;
        sb.push_back({model_expand(data_in, m_mode), s, eo});
        m_idx = eo ? 0 : m_idx + 1;
      end
    end
  end

  task automatic send_raw(input logic [11:0] d, input logic s, input logic e);
    int n = 0;
    data_in = d; sop_in = s; eop_in = e; valid_in = 1'b1;
    while (!ready_in && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready_in=%b expected 1 within 100 cycles", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
  endtask

  task automatic send_px(input logic [11:0] d);
    send_raw(d, tx_idx == 0, tx_idx == NP - 1);
    tx_idx = (tx_idx == NP - 1) ? 0 : tx_idx + 1;
  endtask

  task automatic finish_frame();
    while (tx_idx != 0) send_px(12'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid, ready_in, startofpacket, endofpacket, sync_err} !== 5'b0 || data !== 30'h0 || frame_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b ri=%b d=%h sop=%b eop=%b err=%b fc=%0d expected all 0",
               valid, ready_in, data, startofpacket, endofpacket, sync_err, frame_count);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", ready_in);
    end
  endtask

  task automatic test_replicate();
    mode = 2'd0;
    for (int i = 0; i < 4; i++) begin
      send_px(12'hA5F);
      checks++;
      if (valid !== 1'b1 || data !== {10'h2A8, 10'h154, 10'h3FC} || startofpacket !== (i == 0)) begin
        errors++;
        $display("FAIL replicate_beat%0d: got v=%b d=%h sop=%b expected v=1 d=%h sop=%b",
                 i, valid, data, startofpacket, {10'h2A8, 10'h154, 10'h3FC}, i == 0);
      end
    end
    finish_frame();
  endtask

  task automatic test_frames();
    repeat (2 * NP) send_px(12'($urandom));
    drain();
    checks++;
    if (frame_count !== 16'd3 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL frames: got fc=%0d err=%b expected fc=3 err=0", frame_count, sync_err);
    end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    fork
      begin
        repeat (3) send_px(12'($urandom));
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 2 || ready_in !== 1'b0 || valid !== 1'b1 || data !== sb[0][31:2]) begin
      errors++;
      $display("FAIL backpressure: got absorbed=%0d ri=%b v=%b d=%h expected 2/0/1/%h",
               sb.size(), ready_in, valid, data, sb[0][31:2]);
    end
    ready = 1'b1;
    wait fork;
    finish_frame();
    drain();
  endtask

  task automatic test_modes();
    mode = 2'd1;
    send_px(12'hF00);
    checks++;
    if (data !== {10'h3C0, 10'h000, 10'h000}) begin
      errors++;
      $display("FAIL zero_fill: got %h expected %h", data, {10'h3C0, 10'h000, 10'h000});
    end
    mode = 2'd2;
    send_px(12'hF00);
    checks++;
    if (data !== {10'h3C0, 10'h000, 10'h000}) begin
      errors++;
      $display("FAIL mode_midframe: got %h expected %h", data, {10'h3C0, 10'h000, 10'h000});
    end
    finish_frame();
    send_px(12'hF00);
    checks++;
    if (data !== {10'h0CC, 10'h0CC, 10'h0CC}) begin
      errors++;
      $display("FAIL grey: got %h expected %h", data, {10'h0CC, 10'h0CC, 10'h0CC});
    end
    finish_frame();
    mode = 2'd3;
    send_px(12'hA5F);
    checks++;
    if (data !== {10'h2A8, 10'h154, 10'h3FC}) begin
      errors++;
      $display("FAIL mode3: got %h expected %h", data, {10'h2A8, 10'h154, 10'h3FC});
    end
    finish_frame();
    drain();
  endtask

  task automatic test_resync();
    mode = 2'd0;
    repeat (5) send_px(12'($urandom));
    send_raw(12'h3C7, 1'b1, 1'b0);
    tx_idx = 1;
    checks++;
    if (startofpacket !== 1'b1 || sync_err !== 1'b1) begin
      errors++;
      $display("FAIL resync: got sop=%b err=%b expected 1/1", startofpacket, sync_err);
    end
    finish_frame();
    checks++;
    if (endofpacket !== 1'b1) begin
      errors++;
      $display("FAIL resync_eop: got %b expected 1 after %0d beats", endofpacket, NP - 1);
    end
    drain();
    checks++;
    if (sync_err !== 1'b1 || m_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_err: got %b expected 1", sync_err);
    end
  endtask

  task automatic test_reset_midframe();
    ready = 1'b0;
    mode = 2'd0;
    data_in = 12'h111; sop_in = 1'b1; eop_in = 1'b0; valid_in = 1'b1;
    @(posedge clk); #1;
    data_in = 12'h222; sop_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || ready_in !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b ri=%b err=%b expected 0/0/0", valid, ready_in, sync_err);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready = 1'b1;
    tx_idx = 0;
    send_raw(12'h123, 1'b0, 1'b0);
    checks++;
    if (startofpacket !== 1'b1 || frame_count !== 16'd0 || sync_err !== 1'b0 ||
        data !== model_expand(12'h123, 2'd0)) begin
      errors++;
      $display("FAIL post_reset_sop: got sop=%b fc=%0d err=%b d=%h expected 1/0/0/%h",
               startofpacket, frame_count, sync_err, data, model_expand(12'h123, 2'd0));
    end
    send_raw(12'h456, 1'b0, 1'b1);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL eop_mismatch: got %b expected 1", sync_err);
    end
    drain();
  endtask

  initial begin
    reset_n = 1'b1; data_in = 12'h0; sop_in = 1'b0; eop_in = 1'b0;
    valid_in = 1'b0; mode = 2'd0; ready = 1'b1;
    test_reset();
    test_replicate();
    test_frames();
    test_back_to_back();
    test_modes();
    test_resync();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
